// File: rtl/silencer_settings_loader.sv
// silencer_settings_loader: fetches five silencer words from BRAM, validates them, commits atomically
package silencer_settings_pkg;
  typedef struct packed {
    logic        UPDATE;
    logic        MODE;
    logic [15:0] UPDATE_RATE_INTENSITY;
    logic [15:0] UPDATE_RATE_PHASE;
    logic [15:0] COMPLETION_STEPS_INTENSITY;
    logic [15:0] COMPLETION_STEPS_PHASE;
  } silencer_settings_t;
endpackage

module silencer_settings_loader
  import silencer_settings_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_FLAG = 'h00,
  parameter logic [ADDR_WIDTH-1:0] ADDR_RATE_INTENSITY = 'h01,
  parameter logic [ADDR_WIDTH-1:0] ADDR_RATE_PHASE = 'h02,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STEPS_INTENSITY = 'h03,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STEPS_PHASE = 'h04
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  output logic                  BRAM_EN,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [15:0]           BRAM_DOUT,
  output logic                  BUSY,
  output logic                  ERR,
  output silencer_settings_t    SETTINGS
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, CHECK} state_t;
  localparam logic [2:0] LAST = 3'(READ_LATENCY - 1);
  state_t state;
  logic [2:0] idx, cnt;
  logic pending, set_ok;
  logic [READ_LATENCY-1:0] pv;
  logic [2:0] pi [READ_LATENCY];
  logic [15:0] shadow [5];
  logic [15:0] shadow_nxt [5];
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [2:0] k);
    return k == 3'd0 ? ADDR_FLAG : k == 3'd1 ? ADDR_RATE_INTENSITY :
           k == 3'd2 ? ADDR_RATE_PHASE : k == 3'd3 ? ADDR_STEPS_INTENSITY : ADDR_STEPS_PHASE;
  endfunction
  // The last word lands on the same edge that enters CHECK, so validate the forwarded shadow.
  always_comb begin
    shadow_nxt = shadow;
    if (pv[READ_LATENCY-1]) shadow_nxt[pi[READ_LATENCY-1]] = BRAM_DOUT;
  end
  assign set_ok = shadow_nxt[1] != 16'd0 && shadow_nxt[2] != 16'd0 &&
                  shadow_nxt[3] != 16'd0 && shadow_nxt[4] != 16'd0;
  assign BUSY = state != IDLE;
  assign BRAM_EN = state == READ;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= 3'd0;
      pending <= 1'b0;
      pv <= '0;
      BRAM_ADDR <= '0;
      ERR <= 1'b0;
      SETTINGS <= '{1'b0, 1'b0, 16'd256, 16'd256, 16'd10, 16'd40};
      for (int i = 0; i < 5; i++) shadow[i] <= 16'd0;
      for (int i = 0; i < READ_LATENCY; i++) pi[i] <= 3'd0;
    end else begin
      pv[0] <= BRAM_EN;
      pi[0] <= idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pi[i] <= pi[i-1];
      end
      shadow <= shadow_nxt;
      SETTINGS.UPDATE <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          pending <= 1'b0;
          if (REQ || pending) begin
            state <= READ;
            idx <= 3'd0;
            BRAM_ADDR <= addr_of(3'd0);
          end
        end
        READ: begin
          pending <= pending | REQ;
          idx <= idx == 3'd4 ? idx : idx + 3'd1;
          BRAM_ADDR <= idx == 3'd4 ? '0 : addr_of(idx + 3'd1);
          cnt <= 3'd0;
          if (idx == 3'd4) state <= DRAIN;
        end
        DRAIN: begin
          pending <= pending | REQ;
          cnt <= cnt + 3'd1;
          if (cnt == LAST) begin
            state <= CHECK;
            if (set_ok)
              SETTINGS <= '{1'b1, shadow_nxt[0][0], shadow_nxt[1], shadow_nxt[2],
                            shadow_nxt[3], shadow_nxt[4]};
            else
              ERR <= 1'b1;
          end
        end
        CHECK: begin
          pending <= REQ;
          idx <= 3'd0;
          state <= pending ? READ : IDLE;
          BRAM_ADDR <= pending ? addr_of(3'd0) : '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_silencer_settings_loader.sv
// tb_silencer_settings_loader: directed checks of fetch timing, commit, reject, coalescing and latency
module tb_silencer_settings_loader;
  import silencer_settings_pkg::*;
  localparam silencer_settings_t RST_VAL = '{1'b0, 1'b0, 16'd256, 16'd256, 16'd10, 16'd40};
  logic clk = 1'b0;
  logic rst = 1'b0, req = 1'b0, req1 = 1'b0, req4 = 1'b0;
  logic en, en1, en4, busy, busy1, busy4, err, err1, err4;
  logic [7:0] addr, addr1, addr4;
  logic [15:0] dout, dout1, dout4;
  silencer_settings_t s, s1, s4;
  logic [15:0] mem [256];
  logic [15:0] d2 [2];
  logic [15:0] d1 [1];
  logic [15:0] d4 [4];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d2[0] <= mem[addr];
    d2[1] <= d2[0];
    d1[0] <= mem[addr1];
    d4[0] <= mem[addr4];
    for (int i = 1; i < 4; i++) d4[i] <= d4[i-1];
  end
  assign dout = d2[1];
  assign dout1 = d1[0];
  assign dout4 = d4[3];
  silencer_settings_loader #(.READ_LATENCY(2)) dut (.CLK(clk), .RST(rst), .REQ(req), .BRAM_EN(en),
    .BRAM_ADDR(addr), .BRAM_DOUT(dout), .BUSY(busy), .ERR(err), .SETTINGS(s));
  silencer_settings_loader #(.READ_LATENCY(1)) dut1 (.CLK(clk), .RST(rst), .REQ(req1), .BRAM_EN(en1),
    .BRAM_ADDR(addr1), .BRAM_DOUT(dout1), .BUSY(busy1), .ERR(err1), .SETTINGS(s1));
  silencer_settings_loader #(.READ_LATENCY(4)) dut4 (.CLK(clk), .RST(rst), .REQ(req4), .BRAM_EN(en4),
    .BRAM_ADDR(addr4), .BRAM_DOUT(dout4), .BUSY(busy4), .ERR(err4), .SETTINGS(s4));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, b, c, d, e);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d; mem[4] = e;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) cyc;
    rst = 1'b0;
    total++; if (s !== RST_VAL) begin bad++; $display("FAIL reset_settings got %h want %h", s, RST_VAL); end
    total++; if (s1 !== RST_VAL) begin bad++; $display("FAIL reset_settings1 got %h want %h", s1, RST_VAL); end
    total++; if (s4 !== RST_VAL) begin bad++; $display("FAIL reset_settings4 got %h want %h", s4, RST_VAL); end
    total++; if ({busy, en, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {busy, en, err}); end
    total++; if (addr !== 8'd0) begin bad++; $display("FAIL reset_addr got %h want 00", addr); end
  endtask

  task automatic test_nominal;
    silencer_settings_t exp;
    logic [7:0] ea;
    exp = '{1'b1, 1'b1, 16'd32, 16'd64, 16'd256, 16'd512};
    load(16'h0001, 16'h0020, 16'h0040, 16'h0100, 16'h0200);
    req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc;
      req = 1'b0;
      ea = k <= 5 ? 8'(k - 1) : 8'd0;
      total++; if (en !== (k <= 5)) begin bad++; $display("FAIL nom_en c%0d got %b want %b", k, en, k <= 5); end
      total++; if (addr !== ea) begin bad++; $display("FAIL nom_addr c%0d got %h want %h", k, addr, ea); end
      total++; if (s.UPDATE !== (k == 8)) begin bad++; $display("FAIL nom_update c%0d got %b want %b", k, s.UPDATE, k == 8); end
      total++; if (busy !== (k <= 8)) begin bad++; $display("FAIL nom_busy c%0d got %b want %b", k, busy, k <= 8); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL nom_err c%0d got %b want 0", k, err); end
      if (k == 8) begin
        total++; if (s !== exp) begin bad++; $display("FAIL nom_commit got %h want %h", s, exp); end
      end
    end
    exp.UPDATE = 1'b0;
    total++; if (s !== exp) begin bad++; $display("FAIL nom_hold got %h want %h", s, exp); end
  endtask

  task automatic test_invalid;
    silencer_settings_t exp;
    exp = '{1'b0, 1'b1, 16'd32, 16'd64, 16'd256, 16'd512};
    mem[2] = 16'h0000;
    req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc;
      req = 1'b0;
      total++; if (err !== (k == 8)) begin bad++; $display("FAIL inv_err c%0d got %b want %b", k, err, k == 8); end
      total++; if (s !== exp) begin bad++; $display("FAIL inv_settings c%0d got %h want %h", k, s, exp); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL inv_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    silencer_settings_t e1, e2;
    int ups = 0;
    e1 = '{1'b1, 1'b0, 16'h0011, 16'h0022, 16'h0033, 16'h0044};
    e2 = '{1'b1, 1'b1, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
    load(16'hFFFE, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cyc;
      req = k == 3 || k == 5;
      if (k == 6) load(16'h0003, 16'h0055, 16'h0066, 16'h0077, 16'h0088);
      if (s.UPDATE === 1'b1) ups++;
      total++; if (s.UPDATE !== (k == 8 || k == 16)) begin bad++; $display("FAIL b2b_update c%0d got %b want %b", k, s.UPDATE, k == 8 || k == 16); end
      total++; if (busy !== (k <= 16)) begin bad++; $display("FAIL b2b_busy c%0d got %b want %b", k, busy, k <= 16); end
      if (k >= 9 && k <= 13) begin
        total++; if (addr !== 8'(k - 9) || en !== 1'b1) begin bad++; $display("FAIL b2b_addr c%0d got %h/%b want %h/1", k, addr, en, 8'(k - 9)); end
      end
      if (k == 8) begin
        total++; if (s !== e1) begin bad++; $display("FAIL b2b_first got %h want %h", s, e1); end
      end
      if (k == 16) begin
        total++; if (s !== e2) begin bad++; $display("FAIL b2b_second got %h want %h", s, e2); end
      end
    end
    total++; if (ups !== 2) begin bad++; $display("FAIL b2b_count got %0d want 2", ups); end
  endtask

  task automatic test_reset_mid;
    silencer_settings_t exp;
    exp = '{1'b1, 1'b0, 16'd1, 16'd2, 16'd3, 16'd4};
    load(16'h0000, 16'd1, 16'd2, 16'd3, 16'd4);
    req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc;
      req = 1'b0;
      rst = k == 4;
      total++; if (s.UPDATE !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_pulse c%0d got %b%b want 00", k, s.UPDATE, err); end
      if (k == 5) begin
        total++; if (s !== RST_VAL) begin bad++; $display("FAIL rmid_settings got %h want %h", s, RST_VAL); end
        total++; if ({busy, en} !== 2'b00) begin bad++; $display("FAIL rmid_idle got %b want 00", {busy, en}); end
      end
    end
    req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc;
      req = 1'b0;
    end
    total++; if (s !== exp) begin bad++; $display("FAIL rmid_reload got %h want %h", s, exp); end
  endtask

  task automatic test_latency_sweep;
    silencer_settings_t exp;
    exp = '{1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    load(16'h0001, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    req1 = 1'b1;
    req4 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cyc;
      req1 = 1'b0;
      req4 = 1'b0;
      total++; if (s1.UPDATE !== (k == 7)) begin bad++; $display("FAIL lat1_update c%0d got %b want %b", k, s1.UPDATE, k == 7); end
      total++; if (s4.UPDATE !== (k == 10)) begin bad++; $display("FAIL lat4_update c%0d got %b want %b", k, s4.UPDATE, k == 10); end
      total++; if (busy1 !== (k <= 7) || busy4 !== (k <= 10)) begin bad++; $display("FAIL lat_busy c%0d got %b%b want %b%b", k, busy1, busy4, k <= 7, k <= 10); end
      if (k == 7) begin
        total++; if (s1 !== exp) begin bad++; $display("FAIL lat1_fields got %h want %h", s1, exp); end
      end
      if (k == 10) begin
        total++; if (s4 !== exp) begin bad++; $display("FAIL lat4_fields got %h want %h", s4, exp); end
      end
    end
    total++; if (err1 !== 1'b0 || err4 !== 1'b0) begin bad++; $display("FAIL lat_err got %b%b want 00", err1, err4); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    cyc;
    test_reset;
    test_nominal;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    test_latency_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
